mode_set_ctrl: RTL and testbench

//  Front-panel controller for the clock. Debounces the five push buttons (up/down/left/right/middle)
//  and sequences the top-level display mode. Runs the edit session for the current time: field

---
 rtl/mode_set_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_mode_set_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mode_set_ctrl.sv
// Front-panel controller: button debounce, mode sequencing,
// and the time edit session with auto-repeat and timeout.
module mode_set_ctrl #(
  parameter int DEB_TICKS    = 5,
  parameter int REP_DELAY    = 500,
  parameter int REP_RATE     = 100,
  parameter int EDIT_TIMEOUT = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1k,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       middle,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [5:0] mode,
  output logic [1:0] field,
  output logic       set_load,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic [2:0] blink_mask
);

  localparam int DW   = $clog2(DEB_TICKS + 1);
  localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int TW   = $clog2(EDIT_TIMEOUT + 1);

  localparam logic [5:0] M_RUN   = 6'd1;
  localparam logic [5:0] M_EDIT  = 6'd2;
  localparam logic [5:0] M_ALARM = 6'd3;

  typedef enum logic [1:0] {
    S_RUN,
    S_EDIT,
    S_ALARM
  } state_t;

  // Button index: 0=down 1=up 2=right 3=left 4=middle
  logic [4:0]    raw;
  logic [4:0]    s1;
  logic [4:0]    s2;
  logic [4:0]    deb;
  logic [4:0]    press;
  logic [4:0]    win;
  logic [DW-1:0] cnt [5];

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_tgt;
  logic          rep_act;
  logic          rep_dn;
  logic          rep_first;
  logic          rep_lvl;
  logic          rep_fire;
  logic          dir_dn;
  logic [1:0]    fld_l;
  logic [1:0]    fld_r;
  logic [4:0]    adj_h;
  logic [5:0]    adj_m;
  logic [5:0]    adj_s;

  assign raw = {middle, left, right, up, down};

  function automatic logic [5:0] inc_w(input logic [5:0] v,
                                       input logic [5:0] mx);
    return (v >= mx) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec_w(input logic [5:0] v,
                                       input logic [5:0] mx);
    return (v == 6'd0 || v > mx) ? mx : v - 6'd1;
  endfunction

  // Two-flop synchroniser for the raw button levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Per-button debounce; one-clk press pulse on accepted 0->1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      press <= '0;
      if (tick_1k) begin
        for (int i = 0; i < 5; i++) begin
          if (s2[i] != deb[i]) begin
            if (cnt[i] == DW'(DEB_TICKS - 1)) begin
              deb[i]   <= s2[i];
              press[i] <= s2[i];
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end else begin
            cnt[i] <= '0;
          end
        end
      end
    end
  end

  // Fixed-priority pick of one press; losers are dropped
  always_comb begin
    win = '0;
    if (press[4])      win[4] = 1'b1;
    else if (press[3]) win[3] = 1'b1;
    else if (press[2]) win[2] = 1'b1;
    else if (press[1]) win[1] = 1'b1;
    else if (press[0]) win[0] = 1'b1;
  end

  // Repeat timing, field stepping and wrapped shadow adjust
  always_comb begin
    rep_lvl  = rep_dn ? deb[0] : deb[1];
    rep_tgt  = rep_first ? RW'(REP_DELAY - 1) : RW'(REP_RATE - 1);
    rep_fire = (state == S_EDIT) && rep_act && tick_1k &&
               rep_lvl && (rep_cnt == rep_tgt);
    dir_dn   = win[0] | (~win[1] & rep_dn);
    fld_l    = (field == 2'd2) ? 2'd0 : field + 2'd1;
    fld_r    = (field == 2'd0) ? 2'd2 : field - 2'd1;
    adj_h    = set_hour;
    adj_m    = set_min;
    adj_s    = set_sec;
    case (field)
      2'd0: adj_s = dir_dn ? dec_w(set_sec, 6'd59)
                           : inc_w(set_sec, 6'd59);
      2'd1: adj_m = dir_dn ? dec_w(set_min, 6'd59)
                           : inc_w(set_min, 6'd59);
      2'd2: adj_h = dir_dn ? 5'(dec_w({1'b0, set_hour}, 6'd23))
                           : 5'(inc_w({1'b0, set_hour}, 6'd23));
      default: ;
    endcase
  end

  // Mode FSM with edit session, repeat and timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      mode       <= M_RUN;
      field      <= 2'd0;
      set_load   <= 1'b0;
      set_hour   <= '0;
      set_min    <= '0;
      set_sec    <= '0;
      blink_mask <= '0;
      to_cnt     <= '0;
      rep_cnt    <= '0;
      rep_act    <= 1'b0;
      rep_dn     <= 1'b0;
      rep_first  <= 1'b0;
    end else begin
      set_load <= 1'b0;
      case (state)
        S_RUN: begin
          if (win[4]) begin
            state      <= S_EDIT;
            mode       <= M_EDIT;
            set_hour   <= cur_hour;
            set_min    <= cur_min;
            set_sec    <= cur_sec;
            field      <= 2'd0;
            blink_mask <= 3'b001;
            to_cnt     <= '0;
            rep_act    <= 1'b0;
          end else if (win[3]) begin
            state <= S_ALARM;
            mode  <= M_ALARM;
          end
        end
        S_ALARM: begin
          if (win[4] || win[3]) begin
            state <= S_RUN;
            mode  <= M_RUN;
          end
        end
        S_EDIT: begin
          if (win[4]) begin
            state      <= S_RUN;
            mode       <= M_RUN;
            set_load   <= 1'b1;
            field      <= 2'd0;
            blink_mask <= '0;
            rep_act    <= 1'b0;
          end else if (!(|win) && !rep_fire && tick_1k &&
                       to_cnt == TW'(EDIT_TIMEOUT - 1)) begin
            state      <= S_RUN;
            mode       <= M_RUN;
            field      <= 2'd0;
            blink_mask <= '0;
            rep_act    <= 1'b0;
          end else begin
            if ((|win) || rep_fire) to_cnt <= '0;
            else if (tick_1k)       to_cnt <= to_cnt + 1'b1;
            if (win[3]) begin
              field      <= fld_l;
              blink_mask <= 3'b001 << fld_l;
              rep_act    <= 1'b0;
            end else if (win[2]) begin
              field      <= fld_r;
              blink_mask <= 3'b001 << fld_r;
              rep_act    <= 1'b0;
            end else if (win[1] || win[0]) begin
              set_hour  <= adj_h;
              set_min   <= adj_m;
              set_sec   <= adj_s;
              rep_act   <= 1'b1;
              rep_dn    <= win[0];
              rep_first <= 1'b1;
              rep_cnt   <= '0;
            end else if (rep_act && tick_1k) begin
              if (!rep_lvl) begin
                rep_act <= 1'b0;
              end else if (rep_fire) begin
                set_hour  <= adj_h;
                set_min   <= adj_m;
                set_sec   <= adj_s;
                rep_cnt   <= '0;
                rep_first <= 1'b0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          state <= S_RUN;
          mode  <= M_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode_set_ctrl.sv
// Directed bench for mode_set_ctrl: debounce, edit,
// load, auto-repeat, priority, timeout and async reset.
module tb_mode_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1k = 1'b0;
  logic [4:0] btn = '0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0;
  logic [5:0] cur_sec = '0;
  logic [5:0] mode;
  logic [1:0] field;
  logic       set_load;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic [2:0] blink_mask;

  int n_chk = 0;
  int n_pass = 0;
  int load_cnt = 0;
  int dbl_cnt = 0;
  logic prev_load = 1'b0;
  logic [5:0] ld_mode;
  logic [4:0] ld_h;
  logic [5:0] ld_m;
  logic [5:0] ld_s;

  localparam int B_DN = 0;
  localparam int B_UP = 1;
  localparam int B_RT = 2;
  localparam int B_LF = 3;
  localparam int B_MD = 4;

  mode_set_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1k    (tick_1k),
    .up         (btn[1]),
    .down       (btn[0]),
    .left       (btn[3]),
    .right      (btn[2]),
    .middle     (btn[4]),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .mode       (mode),
    .field      (field),
    .set_load   (set_load),
    .set_hour   (set_hour),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .blink_mask (blink_mask)
  );

  always #5 clk = ~clk;

  // 1 kHz stand-in: one-clk pulse every other clk
  always @(posedge clk) tick_1k <= ~tick_1k;

  // Load pulse monitor
  always @(negedge clk) begin
    if (set_load) begin
      load_cnt++;
      ld_mode = mode;
      ld_h = set_hour;
      ld_m = set_min;
      ld_s = set_sec;
    end
    if (set_load && prev_load) dbl_cnt++;
    prev_load = set_load;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic ticks(input int n);
    repeat (2 * n) @(negedge clk);
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    ticks(8);
    btn[b] = 1'b0;
    ticks(8);
  endtask

  initial begin
    cur_hour = 5'd12;
    cur_min  = 6'd34;
    cur_sec  = 6'd56;
    repeat (3) @(negedge clk);
    chk("rst_mode", mode, 6'd1);
    chk("rst_field", field, 2'd0);
    chk("rst_blink", blink_mask, 3'd0);
    chk("rst_set", {set_hour, set_min, set_sec}, 17'd0);
    rst_n = 1'b1;
    ticks(2);

    // bounce middle, then a clean hold
    repeat (3) begin
      btn[B_MD] = 1'b1;
      @(negedge clk);
      btn[B_MD] = 1'b0;
      repeat (3) @(negedge clk);
    end
    btn[B_MD] = 1'b1;
    ticks(8);
    btn[B_MD] = 1'b0;
    ticks(8);
    chk("t1_mode", mode, 6'd2);
    chk("t1_load", load_cnt, 0);
    chk("t1_hour", set_hour, 5'd12);
    chk("t1_min", set_min, 6'd34);
    chk("t1_sec", set_sec, 6'd56);
    chk("t1_blink", blink_mask, 3'b001);
    chk("t1_field", field, 2'd0);

    // sec wrap and hour wrap
    repeat (3) press(B_UP);
    chk("t2_sec59", set_sec, 6'd59);
    press(B_UP);
    chk("t2_sec0", set_sec, 6'd0);
    chk("t2_min", set_min, 6'd34);
    press(B_LF);
    press(B_LF);
    chk("t2_field2", field, 2'd2);
    repeat (12) press(B_DN);
    chk("t2_hour0", set_hour, 5'd0);
    press(B_DN);
    chk("t2_hour23", set_hour, 5'd23);
    chk("t2_blink", blink_mask, 3'b100);
    press(B_RT);
    chk("t2_rt_field", field, 2'd1);
    chk("t2_rt_blink", blink_mask, 3'b010);
    press(B_RT);
    press(B_RT);
    chk("t2_rt_wrap", field, 2'd2);
    press(B_LF);
    chk("t2_lf_wrap", field, 2'd0);
    press(B_LF);
    press(B_LF);

    // commit edit
    press(B_MD);
    chk("t3_loads", load_cnt, 1);
    chk("t3_ld_mode", ld_mode, 6'd1);
    chk("t3_ld_val", {ld_h, ld_m, ld_s}, {5'd23, 6'd34, 6'd0});
    chk("t3_mode", mode, 6'd1);
    chk("t3_blink", blink_mask, 3'd0);
    chk("t3_field", field, 2'd0);
    chk("t3_hold", {set_hour, set_min, set_sec},
        {5'd23, 6'd34, 6'd0});

    // alarm view ignores up
    press(B_LF);
    chk("alm_mode", mode, 6'd3);
    press(B_UP);
    chk("alm_up", mode, 6'd3);
    press(B_MD);
    chk("alm_exit", mode, 6'd1);
    chk("alm_noload", load_cnt, 1);

    // auto-repeat on minutes
    press(B_MD);
    press(B_LF);
    chk("t4_field", field, 2'd1);
    btn[B_UP] = 1'b1;
    ticks(760);
    btn[B_UP] = 1'b0;
    ticks(10);
    chk("t4_min", set_min, 6'd38);
    chk("t4_sec", set_sec, 6'd56);
    press(B_MD);
    chk("t4_loads", load_cnt, 2);
    chk("t4_ld_min", ld_m, 6'd38);

    // simultaneous middle+up in RUN, then timeout
    cur_hour = 5'd1;
    cur_min  = 6'd2;
    cur_sec  = 6'd3;
    btn[B_MD] = 1'b1;
    btn[B_UP] = 1'b1;
    ticks(8);
    btn = '0;
    ticks(8);
    chk("t5_mode", mode, 6'd2);
    chk("t5_sec", set_sec, 6'd3);
    ticks(9975);
    chk("t5_pre_to", mode, 6'd2);
    ticks(30);
    chk("t5_to_mode", mode, 6'd1);
    chk("t5_to_load", load_cnt, 2);
    chk("t5_to_blink", blink_mask, 3'd0);

    // async reset mid-edit
    press(B_MD);
    press(B_UP);
    chk("t6_pre", set_sec, 6'd4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_mode", mode, 6'd1);
    chk("t6_set", {set_hour, set_min, set_sec}, 17'd0);
    chk("t6_blink", blink_mask, 3'd0);
    chk("t6_field", field, 2'd0);
    chk("t6_load", set_load, 1'b0);
    ticks(3);
    rst_n = 1'b1;
    ticks(20);
    chk("t6_noload", load_cnt, 2);
    chk("t6_mode_after", mode, 6'd1);
    chk("dbl_load", dbl_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
